// File: rtl/ps2_mouse_stream_ctrl.sv
// ps2_mouse_stream_ctrl
// Aligns and validates 3-byte PS/2 stream-mode packets, publishes deltas,
// buttons and a saturated screen cursor, and asks for re-initialization
// after ERR_LIMIT consecutive framing/parity/timeout errors.
module ps2_mouse_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 54000,
  parameter int ERR_LIMIT      = 3,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_error,
  input  logic       init_done,
  output logic       reinit_req,
  output logic [8:0] mouse_dx,
  output logic [8:0] mouse_dy,
  output logic [2:0] buttons,
  output logic       packet_ready,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       sync_error,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    BYTE0     = 3'd1,
    BYTE1     = 3'd2,
    BYTE2     = 3'd3,
    REINIT    = 3'd4
  } state_e;

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ERR_W  = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [ERR_W-1:0]  ERR_LAST   = ERR_W'(ERR_LIMIT - 1);
  localparam logic [11:0]       X_MAX_12   = 12'(X_MAX);
  localparam logic [11:0]       Y_MAX_12   = 12'(Y_MAX);
  localparam logic [9:0]        X_RST      = 10'(X_MAX / 2);
  localparam logic [9:0]        Y_RST      = 10'(Y_MAX / 2);

  state_e              state_q, state_d;
  logic [2:0]          btn_lat_q, btn_lat_d;
  logic                xsign_q, xsign_d, ysign_q, ysign_d, ovf_q, ovf_d;
  logic [7:0]          xbyte_q, xbyte_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                reinit_req_q, reinit_req_d;
  logic [8:0]          dx_q, dx_d, dy_q, dy_d;
  logic [2:0]          buttons_q, buttons_d;
  logic                pkt_q, pkt_d, sync_err_q, sync_err_d;
  logic [9:0]          cx_q, cx_d, cy_q, cy_d;

  // Candidate deltas and cursor positions for a packet completing this cycle.
  logic [8:0]  dx_new, dy_new;
  logic signed [11:0] sum_x, sum_y;
  logic [9:0]  sat_x, sat_y;

  assign dx_new = {xsign_q, xbyte_q};
  assign dy_new = {ysign_q, rx_data};
  assign sum_x  = $signed({2'b00, cx_q}) + $signed({{3{dx_new[8]}}, dx_new});
  assign sum_y  = $signed({2'b00, cy_q}) - $signed({{3{dy_new[8]}}, dy_new});
  assign sat_x  = sum_x[11] ? 10'd0 : ((12'(sum_x) > X_MAX_12) ? X_MAX_12[9:0] : sum_x[9:0]);
  assign sat_y  = sum_y[11] ? 10'd0 : ((12'(sum_y) > Y_MAX_12) ? Y_MAX_12[9:0] : sum_y[9:0]);

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    logic err_evt;
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    btn_lat_d    = btn_lat_q;
    xsign_d      = xsign_q;
    ysign_d      = ysign_q;
    ovf_d        = ovf_q;
    xbyte_d      = xbyte_q;
    err_cnt_d    = err_cnt_q;
    idle_d       = '0;
    dx_d         = dx_q;
    dy_d         = dy_q;
    buttons_d    = buttons_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    pkt_d        = 1'b0;
    sync_err_d   = 1'b0;
    err_evt      = 1'b0;

    if (!init_done && (state_q == BYTE0 || state_q == BYTE1 || state_q == BYTE2)) begin
      // Mouse lost stream mode: drop everything, not counted as an error.
      state_d = WAIT_INIT;
    end else begin
      unique case (state_q)
        WAIT_INIT: if (init_done) state_d = BYTE0;
        BYTE0: begin
          if (rx_error) err_evt = 1'b1;
          else if (rx_ready) begin
            if (rx_data[3]) begin
              btn_lat_d = rx_data[2:0];
              xsign_d   = rx_data[4];
              ysign_d   = rx_data[5];
              ovf_d     = rx_data[6] | rx_data[7];
              state_d   = BYTE1;
            end else begin
              err_evt = 1'b1;
            end
          end
        end
        BYTE1: begin
          idle_d = idle_q + 1'b1;
          if (rx_error) err_evt = 1'b1;
          else if (rx_ready) begin
            xbyte_d = rx_data;
            idle_d  = '0;
            state_d = BYTE2;
          end else if (idle_q == IDLE_LIMIT) err_evt = 1'b1;
        end
        BYTE2: begin
          idle_d = idle_q + 1'b1;
          if (rx_error) err_evt = 1'b1;
          else if (rx_ready) begin
            idle_d    = '0;
            state_d   = BYTE0;
            pkt_d     = 1'b1;
            err_cnt_d = '0;
            buttons_d = btn_lat_q;
            if (ovf_q) begin
              dx_d = '0;
              dy_d = '0;
            end else begin
              dx_d = dx_new;
              dy_d = dy_new;
              cx_d = sat_x;
              cy_d = sat_y;
            end
          end else if (idle_q == IDLE_LIMIT) err_evt = 1'b1;
        end
        REINIT:  if (!init_done) state_d = WAIT_INIT;
        default: state_d = WAIT_INIT;
      endcase

      if (err_evt) begin
        sync_err_d = 1'b1;
        idle_d     = '0;
        if (err_cnt_q >= ERR_LAST) begin
          err_cnt_d = '0;
          state_d   = REINIT;
        end else begin
          err_cnt_d = err_cnt_q + 1'b1;
          state_d   = BYTE0;
        end
      end
    end

    reinit_req_d = (state_d == REINIT);
  end

  // Single register stage for state, packet assembly and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_INIT;
      btn_lat_q    <= '0;
      xsign_q      <= 1'b0;
      ysign_q      <= 1'b0;
      ovf_q        <= 1'b0;
      xbyte_q      <= '0;
      err_cnt_q    <= '0;
      idle_q       <= '0;
      reinit_req_q <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      buttons_q    <= '0;
      pkt_q        <= 1'b0;
      sync_err_q   <= 1'b0;
      cx_q         <= X_RST;
      cy_q         <= Y_RST;
    end else begin
      state_q      <= state_d;
      btn_lat_q    <= btn_lat_d;
      xsign_q      <= xsign_d;
      ysign_q      <= ysign_d;
      ovf_q        <= ovf_d;
      xbyte_q      <= xbyte_d;
      err_cnt_q    <= err_cnt_d;
      idle_q       <= idle_d;
      reinit_req_q <= reinit_req_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      buttons_q    <= buttons_d;
      pkt_q        <= pkt_d;
      sync_err_q   <= sync_err_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  assign reinit_req   = reinit_req_q;
  assign mouse_dx     = dx_q;
  assign mouse_dy     = dy_q;
  assign buttons      = buttons_q;
  assign packet_ready = pkt_q;
  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign sync_error   = sync_err_q;
  assign state_dbg    = state_q;

endmodule
